// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port synchronous data RAM between the
// instruction-fetch stage, the memory-access stage and the debug read port.
// One access is granted per cycle and read data returns one cycle later.
// The debug port has a starvation guard, so its reads always complete while
// the CPU is running.
module cpu_mem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {
    ARB_NORM,
    ARB_DBG_FORCE
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM,
    OWN_DBG
  } owner_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       grant_if, grant_mem, grant_dbg;

  // Pick at most one winner; debug jumps the queue only once it has starved.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    grant_dbg = 1'b0;
    if (!rst) begin
      if (state_q == ARB_DBG_FORCE && dbg_req) begin
        grant_dbg = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (dbg_req) begin
        grant_dbg = 1'b1;
      end
    end
  end

  // Steer the winner onto the RAM port; only a MEM winner may write.
  always_comb begin
    ram_en    = grant_if | grant_mem | grant_dbg;
    ram_we    = grant_mem & mem_we;
    ram_wdata = mem_wdata;
    ram_addr  = '0;
    if (grant_mem) begin
      ram_addr = mem_addr;
    end else if (grant_dbg) begin
      ram_addr = dbg_addr;
    end else if (grant_if) begin
      ram_addr = if_addr;
    end
  end

  // Next owner of the read data and next starvation/FSM state.
  always_comb begin
    owner_d = OWN_NONE;
    if (grant_if) begin
      owner_d = OWN_IF;
    end else if (grant_mem && !mem_we) begin
      owner_d = OWN_MEM;
    end else if (grant_dbg) begin
      owner_d = OWN_DBG;
    end

    starve_cnt_d = '0;
    state_d      = ARB_NORM;
    if (state_q == ARB_NORM && dbg_req && !grant_dbg) begin
      starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 8'd1;
      if (starve_cnt_d == LIMIT) begin
        state_d = ARB_DBG_FORCE;
      end
    end
  end

  // Register FSM state, starvation count and read owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_NORM;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign if_gnt  = grant_if;
  assign mem_gnt = grant_mem;
  assign dbg_gnt = grant_dbg;

  // A read granted just before reset must not surface during reset either.
  assign if_rvalid  = !rst && (owner_q == OWN_IF);
  assign mem_rvalid = !rst && (owner_q == OWN_MEM);
  assign dbg_rvalid = !rst && (owner_q == OWN_DBG);

  assign if_rdata  = ram_rdata;
  assign mem_rdata = ram_rdata;
  assign dbg_rdata = ram_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: drives the three requesters against a behavioural
// RAM and compares every response with a reference model of the arbitration
// rules (fixed priorities, starvation escalation, one-cycle read return).
module tb_cpu_mem_arbiter;

  localparam int AW           = 10;
  localparam int DW           = 32;
  localparam int STARVE_LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we, dbg_req;
  logic [AW-1:0] if_addr, mem_addr, dbg_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_gnt, mem_gnt, dbg_gnt;
  logic          if_rvalid, mem_rvalid, dbg_rvalid;
  logic [DW-1:0] if_rdata, mem_rdata, dbg_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: denied debug cycles, escalation flag, pending read.
  int            mdl_cnt;
  bit            mdl_forced;
  int            exp_who;
  logic [DW-1:0] exp_data;

  cpu_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM seen by the arbiter.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Expected winner (0 none, 1 IF, 2 MEM, 3 DBG) from the arbitration rules.
  function automatic int model_winner();
    if (rst) return 0;
    if (mdl_forced && dbg_req) return 3;
    if (mem_req) return 2;
    if (if_req) return 1;
    if (dbg_req) return 3;
    return 0;
  endfunction

  function automatic logic [AW-1:0] winner_addr(input int w);
    case (w)
      1:       return if_addr;
      2:       return mem_addr;
      3:       return dbg_addr;
      default: return '0;
    endcase
  endfunction

  // Update the model with the outcome of the current cycle.
  task automatic model_advance(input int w);
    if (rst) begin
      mdl_cnt    = 0;
      mdl_forced = 0;
      exp_who    = 0;
      return;
    end
    exp_who = 0;
    case (w)
      1: begin exp_who = 1; exp_data = ref_mem[if_addr]; end
      2: begin
        if (mem_we) ref_mem[mem_addr] = mem_wdata;
        else begin exp_who = 2; exp_data = ref_mem[mem_addr]; end
      end
      3: begin exp_who = 3; exp_data = ref_mem[dbg_addr]; end
      default: ;
    endcase
    if (mdl_forced) begin
      mdl_forced = 0;
      mdl_cnt    = 0;
    end else if (dbg_req && w != 3) begin
      mdl_cnt    = (mdl_cnt + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mdl_cnt + 1;
      mdl_forced = (mdl_cnt == STARVE_LIMIT);
    end else begin
      mdl_cnt = 0;
    end
  endtask

  task automatic next_cycle();
    model_advance(model_winner());
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; mem_req = 0; dbg_req = 0; mem_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; mem_req = 1; dbg_req = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if ({if_gnt, mem_gnt, dbg_gnt, ram_en, ram_we} !== 5'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_gnt: got %b expected 00000", {if_gnt, mem_gnt, dbg_gnt, ram_en, ram_we});
      end
      n_checks++;
      if ({if_rvalid, mem_rvalid, dbg_rvalid} !== 3'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_rvalid: got %b expected 000", {if_rvalid, mem_rvalid, dbg_rvalid});
      end
      next_cycle();
    end
    rst = 0;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({if_gnt, mem_gnt, dbg_gnt, ram_en, if_rvalid, mem_rvalid, dbg_rvalid} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %b expected 0000000",
               {if_gnt, mem_gnt, dbg_gnt, ram_en, if_rvalid, mem_rvalid, dbg_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 10'h010;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 10'h010) begin
      n_fail++;
      $display("[TB] FAIL if_read_grant: got gnt=%b en=%b addr=%h expected 1 1 010", if_gnt, ram_en, ram_addr);
    end
    next_cycle();
    if_req = 0;
    @(negedge clk);
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== init_word(16)) begin
      n_fail++;
      $display("[TB] FAIL if_read_data: got v=%b d=%h expected 1 %h", if_rvalid, if_rdata, init_word(16));
    end
    next_cycle();
  endtask

  task automatic test_mem_write_read();
    mem_req = 1; mem_we = 1; mem_addr = 10'h020; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (mem_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h020 || ram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL mem_write_drive: got gnt=%b we=%b addr=%h wd=%h expected 1 1 020 deadbeef",
               mem_gnt, ram_we, ram_addr, ram_wdata);
    end
    next_cycle();
    mem_we = 0;
    @(negedge clk);
    n_checks++;
    if (mem_rvalid !== 1'b0 || ram_we !== 1'b0 || mem_gnt !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mem_write_no_rvalid: got rv=%b we=%b gnt=%b expected 0 0 1", mem_rvalid, ram_we, mem_gnt);
    end
    next_cycle();
    mem_req = 0;
    @(negedge clk);
    n_checks++;
    if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL mem_read_back: got v=%b d=%h expected 1 deadbeef", mem_rvalid, mem_rdata);
    end
    next_cycle();
  endtask

  task automatic test_if_mem_collision();
    if_req = 1; if_addr = 10'h044; mem_req = 1; mem_we = 0; mem_addr = 10'h020;
    @(negedge clk);
    n_checks++;
    if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL collision_mem_first: got mem=%b if=%b expected 1 0", mem_gnt, if_gnt);
    end
    next_cycle();
    mem_req = 0;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1 || ram_addr !== 10'h044 || mem_rvalid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL collision_if_next: got gnt=%b addr=%h rv=%b d=%h expected 1 044 1 deadbeef",
               if_gnt, ram_addr, mem_rvalid, mem_rdata);
    end
    next_cycle();
    if_req = 0;
    @(negedge clk);
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== init_word(68)) begin
      n_fail++;
      $display("[TB] FAIL collision_if_data: got v=%b d=%h expected 1 %h", if_rvalid, if_rdata, init_word(68));
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    int waited = 0;
    bit got = 0;
    dbg_req = 1; dbg_addr = 10'h155; if_req = 1; if_addr = 10'h011;
    mem_req = 1; mem_we = 0;
    while (!got && waited < 40) begin
      mem_addr = 10'($urandom_range(0, 63));
      @(negedge clk);
      waited++;
      if (dbg_gnt === 1'b1) got = 1;
      next_cycle();
    end
    n_checks++;
    if (!got || waited != STARVE_LIMIT + 1) begin
      n_fail++;
      $display("[TB] FAIL starve_grant_cycle: got granted=%0d at cycle %0d expected 1 at cycle %0d",
               got, waited, STARVE_LIMIT + 1);
    end
    dbg_req = 0;
    @(negedge clk);
    n_checks++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== init_word(341)) begin
      n_fail++;
      $display("[TB] FAIL starve_dbg_data: got v=%b d=%h expected 1 %h", dbg_rvalid, dbg_rdata, init_word(341));
    end
    n_checks++;
    if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL starve_back_to_norm: got mem=%b if=%b expected 1 0", mem_gnt, if_gnt);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    int waited = 0;
    bit got = 0;
    dbg_req = 1; dbg_addr = 10'h0AA; mem_req = 1; mem_we = 0; mem_addr = 10'h001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      next_cycle();
    end
    mem_req = 0; if_req = 1; if_addr = 10'h033;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_if_grant: got %b expected 1", if_gnt);
    end
    next_cycle();
    if_req = 0; rst = 1;
    @(negedge clk);
    n_checks++;
    if (if_rvalid !== 1'b0 || dbg_gnt !== 1'b0 || ram_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_during_reset: got rv=%b dbg=%b en=%b expected 0 0 0", if_rvalid, dbg_gnt, ram_en);
    end
    next_cycle();
    rst = 0; mem_req = 1;
    while (!got && waited < 40) begin
      @(negedge clk);
      waited++;
      if (waited == 1) begin
        n_checks++;
        if (if_rvalid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL rstmid_no_rvalid: got %b expected 0", if_rvalid);
        end
      end
      if (dbg_gnt === 1'b1) got = 1;
      next_cycle();
    end
    n_checks++;
    if (!got || waited != STARVE_LIMIT + 1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_counter_cleared: got granted=%0d at cycle %0d expected 1 at cycle %0d",
               got, waited, STARVE_LIMIT + 1);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    int last_w = 0;
    int w;
    logic [2:0] exp_g, exp_rv;
    for (int c = 0; c < 400; c++) begin
      if (!if_req || last_w == 1) begin
        if_req  = ($urandom_range(0, 9) < 6);
        if_addr = 10'($urandom_range(0, 15));
      end
      if (!mem_req || last_w == 2) begin
        mem_req   = ($urandom_range(0, 9) < 8);
        mem_we    = ($urandom_range(0, 2) == 0);
        mem_addr  = 10'($urandom_range(0, 15));
        mem_wdata = $urandom();
      end
      if (!dbg_req || last_w == 3) begin
        dbg_req  = ($urandom_range(0, 9) < 3);
        dbg_addr = 10'($urandom_range(0, 15));
      end
      @(negedge clk);
      w      = model_winner();
      exp_g  = {w == 1, w == 2, w == 3};
      exp_rv = {exp_who == 1, exp_who == 2, exp_who == 3};
      n_checks++;
      if ({if_gnt, mem_gnt, dbg_gnt} !== exp_g) begin
        n_fail++;
        $display("[TB] FAIL rnd_gnt cycle %0d: got %b expected %b", c, {if_gnt, mem_gnt, dbg_gnt}, exp_g);
      end
      n_checks++;
      if (ram_en !== (w != 0) || ram_we !== (w == 2 && mem_we) || ram_wdata !== mem_wdata ||
          (w != 0 && ram_addr !== winner_addr(w))) begin
        n_fail++;
        $display("[TB] FAIL rnd_ram cycle %0d: got en=%b we=%b addr=%h expected en=%b we=%b addr=%h",
                 c, ram_en, ram_we, ram_addr, w != 0, w == 2 && mem_we, winner_addr(w));
      end
      n_checks++;
      if ({if_rvalid, mem_rvalid, dbg_rvalid} !== exp_rv) begin
        n_fail++;
        $display("[TB] FAIL rnd_rvalid cycle %0d: got %b expected %b", c, {if_rvalid, mem_rvalid, dbg_rvalid}, exp_rv);
      end
      if (exp_who != 0) begin
        n_checks++;
        if (ram_rdata !== exp_data || if_rdata !== exp_data || mem_rdata !== exp_data || dbg_rdata !== exp_data) begin
          n_fail++;
          $display("[TB] FAIL rnd_rdata cycle %0d: got %h expected %h", c, ram_rdata, exp_data);
        end
      end
      last_w = w;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    mdl_cnt = 0; mdl_forced = 0; exp_who = 0; exp_data = '0;
    rst = 1; idle_inputs();
    if_addr = '0; mem_addr = '0; dbg_addr = '0; mem_wdata = '0;
    test_reset();
    test_if_read();
    test_mem_write_read();
    test_if_mem_collision();
    test_starvation();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port synchronous data RAM between three requesters: the pipeline instruction-fetch stage (IF), the pipeline memory-access stage (MEM) and the debug read port used by the top-level bench/monitor.
- Grants one access per cycle, returns read data with fixed 1-cycle latency, and produces per-requester stall information via gnt.
- Includes a starvation guard so debug reads always complete while the CPU is running.
- Sits inside the CPU top, between the pipeline stages, the debug port and the RAM.

Parameters:
AW, 10, word-address width
DW, 32, data width
STARVE_LIMIT, 8, consecutive denied debug cycles before debug is forced to top priority (legal range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  IF read request; held until if_gnt
if_addr  in  AW  IF word address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  if_rdata valid
if_rdata  out  DW  IF read data
mem_req  in  1  MEM request; held until mem_gnt
mem_we  in  1  1 = write, 0 = read
mem_addr  in  AW  MEM word address
mem_wdata  in  DW  MEM write data
mem_gnt  out  1  MEM request accepted this cycle
mem_rvalid  out  1  mem_rdata valid (reads only)
mem_rdata  out  DW  MEM read data
dbg_req  in  1  debug read request; held until dbg_gnt
dbg_addr  in  AW  debug word address
dbg_gnt  out  1  debug request accepted
dbg_rvalid  out  1  dbg_rdata valid
dbg_rdata  out  DW  debug read data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data; valid the cycle after ram_en & ~ram_we

Behaviour:
- Grants are combinational from the current requests and the registered state; at most one gnt is high per cycle.
- While rst=1, all gnt outputs, ram_en and ram_we are 0.
- Reset values: all rvalid = 0, owner register = none, starvation counter = 0, FSM = ARB_NORM.
- FSM states:
  - ARB_NORM: priority MEM > IF > DBG.
  - ARB_DBG_FORCE: priority DBG > MEM > IF.
- Starvation counter:
  - In ARB_NORM, increments on each cycle with dbg_req=1 and dbg_gnt=0; saturates at STARVE_LIMIT.
  - Clears to 0 on dbg_gnt or when dbg_req=0.
- Transitions:
  - ARB_NORM -> ARB_DBG_FORCE when the counter reaches STARVE_LIMIT, effective the next cycle.
  - ARB_DBG_FORCE -> ARB_NORM on the cycle after dbg_gnt.
  - ARB_DBG_FORCE -> ARB_NORM if dbg_req drops.
- RAM drive on a granted cycle: ram_en=1, ram_addr = winner address. ram_we = mem_we only when MEM wins; otherwise 0. ram_wdata = mem_wdata always.
- No grant: ram_en=0, ram_we=0.
- Read latency:
  - The owner register records the read winner (IF/MEM/DBG) at grant.
  - Next cycle, exactly that requester's rvalid = 1 for one cycle; all others 0.
  - Writes never raise mem_rvalid.
- Data routing: all rdata outputs are driven from ram_rdata and are meaningful only while the matching rvalid=1.
- Back-to-back: a new grant is allowed in the same cycle an rvalid is returned (full throughput, 1 access/cycle).
- Stall: requester stalls while req=1 and gnt=0; the address and data it presents must stay stable while stalled.
- Reset mid-read: a read granted in the cycle before rst produces no rvalid after reset; the owner is cleared.
- Simultaneous all-three requests in ARB_NORM: MEM is granted. IF is granted the next cycle if MEM has dropped its request; otherwise MEM keeps priority.

Test Plan:
- Reset then idle -> all gnt/rvalid = 0, ram_en=0, counter=0.
- IF read addr 0x010 alone -> if_gnt same cycle, ram_addr=0x010; next cycle if_rvalid=1, if_rdata = RAM[0x010].
- MEM write addr 0x020 data 0xDEADBEEF, then MEM read 0x020 -> write cycle: ram_we=1, no mem_rvalid; read: mem_rvalid next cycle with 0xDEADBEEF.
- IF and MEM both request same cycle -> mem_gnt=1, if_gnt=0; IF granted the following cycle after MEM drops.
- dbg_req held while MEM and IF request every cycle, STARVE_LIMIT=8 -> dbg_gnt on cycle 9 of the wait (ARB_DBG_FORCE); dbg_rvalid one cycle later; FSM returns to ARB_NORM.
- IF read granted, rst asserted the next cycle -> if_rvalid stays 0, FSM = ARB_NORM, counter=0.
